// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - PS/2 receiver frame constants, FSM state type and parity helper
package ps2_pkg;

    localparam int DATA_BITS = 8;
    localparam int BIT_CNT_W = $clog2(DATA_BITS);
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT = 1'b1;
    localparam logic ODD_PARITY = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_state_t;

    function automatic logic parity_ok(input logic [DATA_BITS-1:0] data, input logic par);
        return (^{data, par}) == ODD_PARITY;
    endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// rtl/ps2_sync_filter.sv - 2-flop synchronizer plus run-length glitch filter for one PS/2 line
module ps2_sync_filter #(
    parameter int FILT_LEN = 8
) (
    input  logic clk,
    input  logic N_RESET,
    input  logic i_raw,
    output logic o_filt
);

    localparam int CW = $clog2(FILT_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

    logic [1:0]    r_sync;
    logic          r_filt;
    logic [CW-1:0] r_cnt;

    // The output flips only once FILT_LEN consecutive synchronized samples disagree with it.
    always_ff @(posedge clk or negedge N_RESET) begin
        if (!N_RESET) begin
            r_sync <= 2'b11;
            r_filt <= 1'b1;
            r_cnt  <= '0;
        end else begin
            r_sync <= {r_sync[0], i_raw};
            if (r_sync[1] != r_filt) begin
                if (r_cnt == CNT_LAST) begin
                    r_filt <= r_sync[1];
                    r_cnt  <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_filt = r_filt;

endmodule

// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 device-to-host frame receiver feeding a scan-code FIFO
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int FILT_LEN    = 8,
    parameter int TIMEOUT_CYC = 100000,
    parameter int DEPTH       = 8
) (
    input  logic                     clk,
    input  logic                     N_RESET,
    input  logic                     ps2Clk,
    input  logic                     ps2Data,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     rx_err,
    output logic                     ovf,
    input  logic                     ovf_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(DATA_BITS - 1);
    localparam logic [AW:0] LVL_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] LVL_ONE = (AW + 1)'(1);

    logic w_clk_f;
    logic w_data_f;
    logic w_fall;
    logic w_frame_ok;
    logic w_push;
    logic w_pop;
    logic w_push_ok;

    ps2_state_t              r_state;
    logic [BIT_CNT_W-1:0]    r_bit_cnt;
    logic [DATA_BITS-1:0]    r_shift;
    logic                    r_parity;
    logic [TW-1:0]           r_timer;
    logic                    r_clk_prev;
    logic                    r_rx_err;

    logic [DATA_BITS-1:0]    r_mem [DEPTH];
    logic [AW-1:0]           r_wr_ptr;
    logic [AW-1:0]           r_rd_ptr;
    logic [AW:0]             r_level;
    logic                    r_ovf;

    ps2_sync_filter #(.FILT_LEN(FILT_LEN)) u_clk_filt (
        .clk     (clk),
        .N_RESET (N_RESET),
        .i_raw   (ps2Clk),
        .o_filt  (w_clk_f)
    );

    ps2_sync_filter #(.FILT_LEN(FILT_LEN)) u_data_filt (
        .clk     (clk),
        .N_RESET (N_RESET),
        .i_raw   (ps2Data),
        .o_filt  (w_data_f)
    );

    assign w_fall     = r_clk_prev & ~w_clk_f;
    assign w_frame_ok = (w_data_f == STOP_BIT) && parity_ok(r_shift, r_parity);
    assign w_push     = w_fall && (r_state == ST_STOP) && w_frame_ok;
    assign w_pop      = (r_level != '0) && out_ready;
    // A full FIFO can still take the byte when the head leaves in the same cycle.
    assign w_push_ok  = w_push && ((r_level < LVL_FULL) || w_pop);

    always_ff @(posedge clk or negedge N_RESET) begin
        if (!N_RESET) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_timer    <= '0;
            r_clk_prev <= 1'b1;
            r_rx_err   <= 1'b0;
        end else begin
            r_clk_prev <= w_clk_f;
            r_rx_err   <= 1'b0;
            if (r_state == ST_IDLE) begin
                r_timer <= '0;
                if (w_fall && (w_data_f == START_BIT)) begin
                    r_state   <= ST_DATA;
                    r_bit_cnt <= '0;
                end
            end else if (w_fall) begin
                r_timer <= '0;
                case (r_state)
                    ST_DATA: begin
                        r_shift <= {w_data_f, r_shift[DATA_BITS-1:1]};
                        if (r_bit_cnt == BIT_LAST) begin
                            r_state <= ST_PARITY;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
                        end
                    end
                    ST_PARITY: begin
                        r_parity <= w_data_f;
                        r_state  <= ST_STOP;
                    end
                    default: begin
                        r_state  <= ST_IDLE;
                        r_rx_err <= ~w_frame_ok;
                    end
                endcase
            end else if (r_timer == TIMER_LAST) begin
                r_state  <= ST_IDLE;
                r_timer  <= '0;
                r_shift  <= '0;
                r_rx_err <= 1'b1;
            end else begin
                r_timer <= r_timer + TW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge N_RESET) begin
        if (!N_RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= r_shift;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
            if (w_push && !w_push_ok) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign out_data  = r_mem[r_rd_ptr];
    assign out_valid = (r_level != '0);
    assign level     = r_level;
    assign rx_err    = r_rx_err;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb/tb_ps2_rx_fifo.sv - self-checking bench for ps2_rx_fifo with a queue-based reference model
module tb_ps2_rx_fifo;

    localparam int FILT_LEN    = 4;
    localparam int TIMEOUT_CYC = 1000;
    localparam int DEPTH       = 8;
    localparam int HALF        = 20;

    logic       clk = 1'b0;
    logic       N_RESET = 1'b0;
    logic       ps2Clk = 1'b1;
    logic       ps2Data = 1'b1;
    logic       out_ready = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic [3:0] level;
    logic       rx_err;
    logic       ovf;

    int         n_vec = 0;
    int         n_bad = 0;
    int         err_pulses = 0;
    int         valid_cycles = 0;
    logic [7:0] exp_q [$];
    logic       exp_ovf = 1'b0;

    always #5 clk = ~clk;

    ps2_rx_fifo #(
        .FILT_LEN    (FILT_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .DEPTH       (DEPTH)
    ) dut (
        .clk       (clk),
        .N_RESET   (N_RESET),
        .ps2Clk    (ps2Clk),
        .ps2Data   (ps2Data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .rx_err    (rx_err),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        #1;
        if (N_RESET) begin
            if (rx_err) err_pulses++;
            if (out_valid) valid_cycles++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("pop_unexpected", 1, 0);
                else chk("pop_data", out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic odd_par(input logic [7:0] d);
        return ~^d;
    endfunction

    task automatic send_bit(input logic b);
        ps2Data = b;
        wait_cyc(HALF);
        ps2Clk = 1'b0;
        wait_cyc(HALF);
        ps2Clk = 1'b1;
    endtask

    task automatic send_partial(input logic [7:0] d, input int nbits);
        send_bit(1'b0);
        for (int i = 0; i < nbits; i++) send_bit(d[i]);
    endtask

    // pop_at_stop pulses out_ready for the one cycle in which the stop-edge push lands.
    task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop,
                              input bit pop_at_stop);
        send_partial(d, 8);
        send_bit(odd_par(d) ^ par_flip);
        ps2Data = stop;
        wait_cyc(HALF);
        ps2Clk = 1'b0;
        if (!par_flip && stop) begin
            if (exp_q.size() < DEPTH || pop_at_stop) exp_q.push_back(d);
            else exp_ovf = 1'b1;
        end
        if (pop_at_stop) begin
            wait_cyc(FILT_LEN + 2);
            out_ready = 1'b1;
            wait_cyc(1);
            out_ready = 1'b0;
            wait_cyc(HALF - FILT_LEN - 3);
        end else begin
            wait_cyc(HALF);
        end
        ps2Clk = 1'b1;
        ps2Data = 1'b1;
        wait_cyc(HALF);
    endtask

    task automatic drain(input bit rnd);
        for (int c = 0; c < 2000 && exp_q.size() > 0; c++) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            wait_cyc(1);
        end
        out_ready = 1'b0;
        wait_cyc(2);
        chk("drain_model_empty", exp_q.size(), 0);
        chk("drain_level", level, 0);
    endtask

    initial begin
        int e0;
        int v0;
        int n;
        int nerr;
        int kind;
        logic [7:0] d;

        wait_cyc(3);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_level", level, 0);
        chk("rst_err", rx_err, 0);
        chk("rst_ovf", ovf, 0);
        N_RESET = 1'b1;
        wait_cyc(5);

        out_ready = 1'b1;
        e0 = err_pulses;
        v0 = valid_cycles;
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        wait_cyc(10);
        chk("good_valid_cycles", valid_cycles - v0, 1);
        chk("good_err", err_pulses - e0, 0);
        chk("good_rx", exp_q.size(), 0);

        e0 = err_pulses;
        send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
        wait_cyc(10);
        chk("par_err_pulses", err_pulses - e0, 1);
        chk("par_level", level, 0);

        out_ready = 1'b0;
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b1, 1'b0);
        wait_cyc(5);
        chk("full_level", level, exp_q.size());
        chk("full_ovf", ovf, exp_ovf);
        drain(1'b0);
        chk("ovf_sticky", ovf, exp_ovf);
        ovf_clr = 1'b1;
        wait_cyc(1);
        ovf_clr = 1'b0;
        exp_ovf = 1'b0;
        wait_cyc(1);
        chk("ovf_cleared", ovf, exp_ovf);

        for (int i = 0; i < 8; i++) send_frame(8'h11 + 8'(i), 1'b0, 1'b1, 1'b0);
        chk("fill_level", level, 8);
        send_frame(8'hAA, 1'b0, 1'b1, 1'b1);
        wait_cyc(5);
        chk("pushpop_level", level, 8);
        chk("pushpop_ovf", ovf, 0);
        drain(1'b0);

        e0 = err_pulses;
        send_partial(8'h3C, 4);
        ps2Data = 1'b1;
        wait_cyc(TIMEOUT_CYC + 100);
        chk("timeout_err", err_pulses - e0, 1);
        chk("timeout_level", level, 0);
        out_ready = 1'b1;
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        wait_cyc(10);
        chk("after_timeout_rx", exp_q.size(), 0);
        chk("after_timeout_err", err_pulses - e0, 1);

        out_ready = 1'b0;
        send_frame(8'h77, 1'b0, 1'b1, 1'b0);
        send_partial(8'hFF, 3);
        ps2Data = 1'b1;
        wait_cyc(HALF / 2);
        N_RESET = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_data", out_data, 0);
        chk("midrst_level", level, 0);
        chk("midrst_err", rx_err, 0);
        chk("midrst_ovf", ovf, 0);
        exp_q.delete();
        exp_ovf = 1'b0;
        wait_cyc(3);
        N_RESET = 1'b1;
        wait_cyc(20);
        out_ready = 1'b1;
        v0 = valid_cycles;
        e0 = err_pulses;
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
        wait_cyc(10);
        chk("postrst_rx", exp_q.size(), 0);
        chk("postrst_valid_cycles", valid_cycles - v0, 1);
        chk("postrst_err", err_pulses - e0, 0);

        e0 = err_pulses;
        v0 = valid_cycles;
        ps2Data = 1'b0;
        for (int g = 0; g < 6; g++) begin
            ps2Clk = 1'b0;
            wait_cyc(FILT_LEN - 1);
            ps2Clk = 1'b1;
            wait_cyc(12);
        end
        ps2Data = 1'b1;
        wait_cyc(30);
        chk("glitch_err", err_pulses - e0, 0);
        chk("glitch_valid", valid_cycles - v0, 0);
        send_frame(8'h33, 1'b0, 1'b1, 1'b0);
        wait_cyc(10);
        chk("after_glitch_rx", exp_q.size(), 0);
        chk("after_glitch_err", err_pulses - e0, 0);

        for (int b = 0; b < 4; b++) begin
            out_ready = 1'b0;
            n = $urandom_range(1, 6);
            nerr = 0;
            e0 = err_pulses;
            for (int k = 0; k < n; k++) begin
                d = 8'($urandom);
                kind = $urandom_range(0, 3);
                if (kind < 2) nerr++;
                send_frame(d, kind == 0, kind != 1, 1'b0);
            end
            wait_cyc(5);
            chk("rnd_err", err_pulses - e0, nerr);
            chk("rnd_level", level, exp_q.size());
            chk("rnd_ovf", ovf, exp_ovf);
            drain(1'b1);
        end

        chk("end_level", level, 0);
        chk("end_ovf", ovf, exp_ovf);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
